// File: rtl/dds_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl_if
// Brief    : Register-bank <-> sweep sequencer bundle (config, strobes, status)
// Revision : 1.0 - initial release
// ============================================================================
interface dds_sweep_ctrl_if #(
    parameter int STEP_WIDTH  = 32,
    parameter int DWELL_WIDTH = 32,
    parameter int COUNT_WIDTH = 16
);
    logic [STEP_WIDTH-1:0]  start_step;
    logic [STEP_WIDTH-1:0]  stop_step;
    logic [STEP_WIDTH-1:0]  delta;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [1:0]             mode;
    logic                   go;
    logic                   abort;

    logic [STEP_WIDTH-1:0]  step_out;
    logic                   busy;
    logic                   done;
    logic                   wrap;
    logic [COUNT_WIDTH-1:0] sweep_count;

    modport master (
        output start_step, stop_step, delta, dwell, mode, go, abort,
        input  step_out, busy, done, wrap, sweep_count
    );

    modport slave (
        input  start_step, stop_step, delta, dwell, mode, go, abort,
        output step_out, busy, done, wrap, sweep_count
    );
endinterface
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Brief    : DDS tuning-word sweep/hop sequencer (single, sawtooth, triangle).
//            Optional macro DDS_SWEEP_EXT_STEP_EN: dwell == 0 means advance on
//            an external ext_step pulse instead of a timed dwell.
// Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int STEP_WIDTH  = 32,
    parameter int DWELL_WIDTH = 32,
    parameter int COUNT_WIDTH = 16
) (
    input wire              clk,
    input wire              reset,
`ifdef DDS_SWEEP_EXT_STEP_EN
    input wire              ext_step,
`endif
    dds_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DWELL   = 2'd1,
        ADVANCE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [STEP_WIDTH-1:0]  r_cur, w_cur_nxt;
    logic [STEP_WIDTH-1:0]  r_start, w_start_nxt;
    logic [STEP_WIDTH-1:0]  r_stop, w_stop_nxt;
    logic [STEP_WIDTH-1:0]  r_orig_start, w_orig_start_nxt;
    logic [STEP_WIDTH-1:0]  r_delta, w_delta_nxt;
    logic [DWELL_WIDTH-1:0] r_dwell_ld, w_dwell_ld_nxt;
    logic [DWELL_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]             r_mode, w_mode_nxt;
    logic                   r_up, w_up_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_wrap, w_wrap_nxt;
    logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                   w_expire;
    logic                   w_repeat;
    logic                   w_tri;

    // Clamped step toward tgt; the extra MSB catches carry/borrow.
    function automatic logic [STEP_WIDTH-1:0] f_advance(
        input logic [STEP_WIDTH-1:0] cur,
        input logic [STEP_WIDTH-1:0] tgt,
        input logic [STEP_WIDTH-1:0] dlt,
        input logic                  up
    );
        logic [STEP_WIDTH:0] sum;
        logic [STEP_WIDTH:0] diff;
        sum  = {1'b0, cur} + {1'b0, dlt};
        diff = {1'b0, cur} - {1'b0, dlt};
        if (dlt == '0)
            f_advance = tgt;
        else if (up)
            f_advance = (sum[STEP_WIDTH] || (sum[STEP_WIDTH-1:0] > tgt)) ? tgt : sum[STEP_WIDTH-1:0];
        else
            f_advance = (diff[STEP_WIDTH] || (diff[STEP_WIDTH-1:0] < tgt)) ? tgt : diff[STEP_WIDTH-1:0];
    endfunction

`ifdef DDS_SWEEP_EXT_STEP_EN
    logic r_ext, w_ext_nxt;
    assign w_expire = r_ext ? ext_step : (r_cnt == DWELL_WIDTH'(1));
`else
    assign w_expire = (r_cnt == DWELL_WIDTH'(1));
`endif

    assign w_repeat = (r_mode == 2'd1);
    assign w_tri    = (r_mode == 2'd2);

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_nxt        = r_cur;
        w_start_nxt      = r_start;
        w_stop_nxt       = r_stop;
        w_orig_start_nxt = r_orig_start;
        w_delta_nxt      = r_delta;
        w_dwell_ld_nxt   = r_dwell_ld;
        w_cnt_nxt        = r_cnt;
        w_mode_nxt       = r_mode;
        w_up_nxt         = r_up;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_wrap_nxt       = 1'b0;
        w_count_nxt      = r_count;
`ifdef DDS_SWEEP_EXT_STEP_EN
        w_ext_nxt        = r_ext;
`endif

        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                if (bus.go && !bus.abort) begin
                    w_start_nxt      = bus.start_step;
                    w_orig_start_nxt = bus.start_step;
                    w_stop_nxt       = bus.stop_step;
                    w_delta_nxt      = bus.delta;
                    w_mode_nxt       = bus.mode;
                    w_up_nxt         = (bus.stop_step >= bus.start_step);
                    w_dwell_ld_nxt   = (bus.dwell == '0) ? DWELL_WIDTH'(1) : bus.dwell;
                    w_cnt_nxt        = (bus.dwell == '0) ? DWELL_WIDTH'(1) : bus.dwell;
                    w_cur_nxt        = bus.start_step;
                    w_busy_nxt       = 1'b1;
                    w_count_nxt      = '0;
                    w_state_nxt      = DWELL;
`ifdef DDS_SWEEP_EXT_STEP_EN
                    w_ext_nxt        = (bus.dwell == '0);
`endif
                end
            end

            // The advance is resolved on the last dwell cycle, so ADVANCE is
            // never held as a registered state and shares this branch.
            DWELL, ADVANCE: begin
                w_state_nxt = DWELL;
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_expire) begin
                    w_cnt_nxt = r_dwell_ld;
                    if (r_cur != r_stop) begin
                        w_cur_nxt = f_advance(r_cur, r_stop, r_delta, r_up);
                    end else if (w_tri) begin
                        w_start_nxt = r_stop;
                        w_stop_nxt  = r_start;
                        w_up_nxt    = !r_up;
                        w_cur_nxt   = f_advance(r_cur, r_start, r_delta, !r_up);
                        if (r_stop == r_orig_start) begin
                            w_wrap_nxt  = 1'b1;
                            w_count_nxt = r_count + COUNT_WIDTH'(1);
                        end
                    end else if (w_repeat) begin
                        w_cur_nxt   = r_orig_start;
                        w_wrap_nxt  = 1'b1;
                        w_count_nxt = r_count + COUNT_WIDTH'(1);
                    end else begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_count_nxt = r_count + COUNT_WIDTH'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - DWELL_WIDTH'(1);
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_start      <= '0;
            r_stop       <= '0;
            r_orig_start <= '0;
            r_delta      <= '0;
            r_dwell_ld   <= '0;
            r_cnt        <= '0;
            r_mode       <= '0;
            r_up         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
            r_count      <= '0;
`ifdef DDS_SWEEP_EXT_STEP_EN
            r_ext        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cur        <= w_cur_nxt;
            r_start      <= w_start_nxt;
            r_stop       <= w_stop_nxt;
            r_orig_start <= w_orig_start_nxt;
            r_delta      <= w_delta_nxt;
            r_dwell_ld   <= w_dwell_ld_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mode       <= w_mode_nxt;
            r_up         <= w_up_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_wrap       <= w_wrap_nxt;
            r_count      <= w_count_nxt;
`ifdef DDS_SWEEP_EXT_STEP_EN
            r_ext        <= w_ext_nxt;
`endif
        end
    end

    assign bus.step_out    = r_cur;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.wrap        = r_wrap;
    assign bus.sweep_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sweep_ctrl
// Brief    : Scoreboard bench for dds_sweep_ctrl (per-cycle expected output
//            records, popped whenever busy/done/wrap is presented).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
`ifdef DDS_SWEEP_EXT_STEP_EN
    logic ext_step = 1'b0;
`endif

    dds_sweep_ctrl_if bus ();

    dds_sweep_ctrl dut (
        .clk      (clk),
        .reset    (reset),
`ifdef DDS_SWEEP_EXT_STEP_EN
        .ext_step (ext_step),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] step;
        logic        busy;
        logic        done;
        logic        wrap;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    total = 0;
    int    bad   = 0;
    string cur_test = "reset";

    task automatic ex(input logic [31:0] s, input logic b, input logic d,
                      input logic w, input logic [15:0] c);
        exp_q.push_back({s, b, d, w, c});
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents activity, pop and compare.
    always @(negedge clk) begin
        if (bus.busy || bus.done || bus.wrap) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s unexpected: got step=%0h busy=%0b done=%0b wrap=%0b cnt=%0d, required no activity",
                         cur_test, bus.step_out, bus.busy, bus.done, bus.wrap, bus.sweep_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.step_out !== mon_e.step || bus.busy !== mon_e.busy || bus.done !== mon_e.done ||
                    bus.wrap !== mon_e.wrap || bus.sweep_count !== mon_e.cnt) begin
                    bad++;
                    $display("FAIL %s: got step=%0h busy=%0b done=%0b wrap=%0b cnt=%0d, required step=%0h busy=%0b done=%0b wrap=%0b cnt=%0d",
                             cur_test, bus.step_out, bus.busy, bus.done, bus.wrap, bus.sweep_count,
                             mon_e.step, mon_e.busy, mon_e.done, mon_e.wrap, mon_e.cnt);
                end
            end
        end
    end

    // Config is scrambled right after go; the DUT must have latched it.
    task automatic cfg_go(input logic [31:0] s, input logic [31:0] e, input logic [31:0] dl,
                          input logic [31:0] dw, input logic [1:0] m, input logic ab);
        @(negedge clk);
        bus.start_step = s;
        bus.stop_step  = e;
        bus.delta      = dl;
        bus.dwell      = dw;
        bus.mode       = m;
        bus.go         = 1'b1;
        bus.abort      = ab;
        @(negedge clk);
        bus.go         = 1'b0;
        bus.abort      = 1'b0;
        bus.start_step = 32'hDEAD_BEEF;
        bus.stop_step  = 32'h1234_5678;
        bus.delta      = 32'h1;
        bus.dwell      = 32'd7;
        bus.mode       = 2'd2;
    endtask

    task automatic abort_after(input int n);
        repeat (n - 1) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: %0d records left, required 0", cur_test, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_step = '0;
        bus.stop_step  = '0;
        bus.delta      = '0;
        bus.dwell      = '0;
        bus.mode       = '0;
        bus.go         = 1'b0;
        bus.abort      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_step", 64'(bus.step_out), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_count", 64'(bus.sweep_count), 64'd0);

        cur_test = "single_up";
        for (int k = 0; k < 3; k++) ex(32'd100, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) ex(32'd110, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) ex(32'd120, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) ex(32'd130, 1, 0, 0, 0);
        ex(32'd130, 0, 1, 0, 1);
        cfg_go(32'd100, 32'd130, 32'd10, 32'd3, 2'd0, 1'b0);
        drain();
        chk("single_up_hold_step", 64'(bus.step_out), 64'd130);
        chk("single_up_count", 64'(bus.sweep_count), 64'd1);
        chk("single_up_done_low", 64'(bus.done), 64'd0);

        cur_test = "overshoot_clamp";
        ex(32'd0, 1, 0, 0, 0); ex(32'd10, 1, 0, 0, 0); ex(32'd20, 1, 0, 0, 0); ex(32'd25, 1, 0, 0, 0);
        ex(32'd25, 0, 1, 0, 1);
        cfg_go(32'd0, 32'd25, 32'd10, 32'd1, 2'd3, 1'b0);
        drain();

        cur_test = "overflow_clamp";
        ex(32'hFFFF_FFF0, 1, 0, 0, 0); ex(32'hFFFF_FFFF, 1, 0, 0, 0); ex(32'hFFFF_FFFF, 0, 1, 0, 1);
        cfg_go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 32'd1, 2'd0, 1'b0);
        drain();

        cur_test = "delta_zero";
        ex(32'd5, 1, 0, 0, 0); ex(32'd5, 1, 0, 0, 0); ex(32'd9, 1, 0, 0, 0); ex(32'd9, 1, 0, 0, 0);
        ex(32'd9, 0, 1, 0, 1);
        cfg_go(32'd5, 32'd9, 32'd0, 32'd2, 2'd0, 1'b0);
        drain();

`ifdef DDS_SWEEP_EXT_STEP_EN
        cur_test = "ext_step";
        for (int k = 0; k < 3; k++) ex(32'd1, 1, 0, 0, 0);
        ex(32'd2, 1, 0, 0, 0); ex(32'd2, 1, 0, 0, 0);
        ex(32'd2, 0, 1, 0, 1);
        cfg_go(32'd1, 32'd2, 32'd1, 32'd0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        ext_step = 1'b1;
        @(negedge clk);
        ext_step = 1'b0;
        @(negedge clk);
        ext_step = 1'b1;
        @(negedge clk);
        ext_step = 1'b0;
        drain();
`else
        cur_test = "dwell_zero";
        ex(32'd1, 1, 0, 0, 0); ex(32'd2, 1, 0, 0, 0); ex(32'd3, 1, 0, 0, 0); ex(32'd3, 0, 1, 0, 1);
        cfg_go(32'd1, 32'd3, 32'd1, 32'd0, 2'd0, 1'b0);
        drain();
`endif

        cur_test = "repeat_down";
        ex(32'd50, 1, 0, 0, 0); ex(32'd40, 1, 0, 0, 0); ex(32'd30, 1, 0, 0, 0);
        ex(32'd50, 1, 0, 1, 1); ex(32'd40, 1, 0, 0, 1); ex(32'd30, 1, 0, 0, 1);
        ex(32'd50, 1, 0, 1, 2); ex(32'd40, 1, 0, 0, 2);
        cfg_go(32'd50, 32'd30, 32'd10, 32'd1, 2'd1, 1'b0);
        abort_after(8);
        chk("repeat_abort_busy", 64'(bus.busy), 64'd0);
        chk("repeat_abort_step", 64'(bus.step_out), 64'd40);
        chk("repeat_abort_count", 64'(bus.sweep_count), 64'd2);
        drain();

        cur_test = "triangle";
        ex(32'd50, 1, 0, 0, 0); ex(32'd40, 1, 0, 0, 0); ex(32'd30, 1, 0, 0, 0);
        ex(32'd40, 1, 0, 0, 0); ex(32'd50, 1, 0, 0, 0); ex(32'd40, 1, 0, 1, 1);
        ex(32'd30, 1, 0, 0, 1); ex(32'd40, 1, 0, 0, 1); ex(32'd50, 1, 0, 0, 1);
        ex(32'd40, 1, 0, 1, 2);
        cfg_go(32'd50, 32'd30, 32'd10, 32'd1, 2'd2, 1'b0);
        abort_after(10);
        chk("triangle_abort_step", 64'(bus.step_out), 64'd40);
        chk("triangle_abort_count", 64'(bus.sweep_count), 64'd2);
        drain();

        cur_test = "equal_repeat";
        ex(32'd7, 1, 0, 0, 0); ex(32'd7, 1, 0, 0, 0); ex(32'd7, 1, 0, 1, 1);
        ex(32'd7, 1, 0, 0, 1); ex(32'd7, 1, 0, 1, 2);
        cfg_go(32'd7, 32'd7, 32'd3, 32'd2, 2'd1, 1'b0);
        abort_after(5);
        chk("equal_repeat_count", 64'(bus.sweep_count), 64'd2);
        drain();

        cur_test = "abort_at_110";
        for (int k = 0; k < 3; k++) ex(32'd100, 1, 0, 0, 0);
        ex(32'd110, 1, 0, 0, 0);
        cfg_go(32'd100, 32'd130, 32'd10, 32'd3, 2'd0, 1'b0);
        abort_after(4);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_step", 64'(bus.step_out), 64'd110);
        chk("abort_done", 64'(bus.done), 64'd0);
        repeat (4) @(negedge clk);
        chk("abort_step_later", 64'(bus.step_out), 64'd110);
        chk("abort_count", 64'(bus.sweep_count), 64'd0);
        drain();

        cur_test = "go_abort_same";
        cfg_go(32'd200, 32'd300, 32'd1, 32'd1, 2'd0, 1'b1);
        chk("go_abort_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("go_abort_step", 64'(bus.step_out), 64'd110);
        drain();

        cur_test = "reset_mid_sweep";
        ex(32'd50, 1, 0, 0, 0); ex(32'd40, 1, 0, 0, 0); ex(32'd30, 1, 0, 0, 0);
        ex(32'd50, 1, 0, 1, 1);
        cfg_go(32'd50, 32'd30, 32'd10, 32'd1, 2'd1, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_step", 64'(bus.step_out), 64'd0);
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_count", 64'(bus.sweep_count), 64'd0);
        chk("midreset_wrap", 64'(bus.wrap), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_stays_idle", 64'(bus.busy), 64'd0);
        drain();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency sweep and hop sequencer for the DDS tuning word. It drives the DDS `step` input, walking it from a start word to a stop word in fixed increments, holding each value for a programmable dwell. It sits between the DDS register bank (config, go and abort strobes) and the `step` port of the DDS core, and reports busy, done, wrap and sweep count back to the register bank.

Parameters:
- STEP_WIDTH, 32: width of tuning words and delta.
- DWELL_WIDTH, 32: width of the dwell counter.
- COUNT_WIDTH, 16: width of the sweep_count output.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-low reset; 0 = reset.
- start_step  in  STEP_WIDTH  first tuning word.
- stop_step  in  STEP_WIDTH  final tuning word.
- delta  in  STEP_WIDTH  unsigned increment magnitude.
- dwell  in  DWELL_WIDTH  cycles each word is held; 0 is treated as 1.
- mode  in  2  0 = single, 1 = repeat sawtooth, 2 = triangle, 3 = single.
- go  in  1  single-cycle start strobe.
- abort  in  1  single-cycle stop strobe.
- step_out  out  STEP_WIDTH  tuning word to the DDS.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at single-sweep completion.
- wrap  out  1  one-cycle pulse each time the sweep returns to start_step.
- sweep_count  out  COUNT_WIDTH  completed sweeps since go; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - State goes to IDLE.
  - step_out = 0, busy = 0, done = 0, wrap = 0, sweep_count = 0.
  - Reset applies mid-sweep and discards the sweep.
- States: IDLE, DWELL, ADVANCE, DONE.
- IDLE:
  - go sampled at cycle N: start_step, stop_step, delta, dwell and mode are latched.
  - Direction is latched as up if stop_step >= start_step, otherwise down.
  - At N+1: step_out = start_step, busy = 1, sweep_count = 0, dwell counter loaded, state = DWELL.
  - Config input changes after the go cycle are ignored until the next go.
- DWELL:
  - Each step_out value is held exactly max(dwell,1) cycles.
  - On expiry, enter ADVANCE.
  - ADVANCE takes zero extra cycles: the new step_out appears on the cycle after the last dwell cycle.
- ADVANCE, computed in STEP_WIDTH+1 bits:
  - Up: next = cur + delta. If next > stop or the addition carries out, next = stop.
  - Down: next = cur − delta. If next < stop or the subtraction borrows, next = stop.
  - delta == 0: next = stop, so the sweep cannot hang.
  - If cur == stop on dwell expiry, this is the end-of-leg event (below), not an advance.
- End of leg, meaning cur == stop and dwell has expired:
  - single: enter DONE. done pulses 1 cycle, busy = 0 on that same cycle, step_out holds stop, sweep_count += 1, then IDLE.
  - repeat: step_out = start_step next cycle, wrap pulses on that cycle, sweep_count += 1.
  - triangle: swap the working start/stop and the direction, then continue advancing.
  - triangle: wrap pulses and sweep_count += 1 only when a leg ends at the original start_step.
- start_step == stop_step:
  - single: hold dwell cycles, then done.
  - repeat and triangle: wrap and count every dwell cycles.
- Strobe interactions:
  - go while busy: ignored.
  - abort while busy: IDLE next cycle, busy = 0, step_out holds its current value, no done, sweep_count retained.
  - abort in IDLE: no effect.
  - go and abort in the same cycle: abort wins, go is dropped.
- Outputs are registered. Latency from go to the first step_out is 1 cycle.

Optional Feature:
Macro DDS_SWEEP_EXT_STEP_EN.
- Defined:
  - Adds input `ext_step` (1 bit).
  - When the latched dwell == 0, the dwell counter is bypassed. Each advance or end-of-leg event occurs on the cycle after `ext_step` is sampled high.
  - `ext_step` while not busy is ignored.
  - dwell != 0 behaves exactly as without the macro.
- Undefined:
  - No `ext_step` port.
  - dwell == 0 behaves as dwell == 1.

Test Plan:
- Reset, then release reset → step_out = 0, busy = 0, sweep_count = 0.
- Single up sweep. start = 100, stop = 130, delta = 10, dwell = 3, mode = 0, go → step_out 100, 110, 120, 130, each for 3 cycles. done pulses 1 cycle, busy falls on the same cycle, sweep_count = 1, step_out stays 130.
- Overshoot and overflow clamp:
  - start = 0, stop = 25, delta = 10 → sequence 0, 10, 20, 25.
  - start = 0xFFFFFFF0, stop = 0xFFFFFFFF, delta = 0x20 → sequence 0xFFFFFFF0, 0xFFFFFFFF.
- Repeat and triangle:
  - mode = 1, start = 50, stop = 30, delta = 10, dwell = 1 → 50, 40, 30, 50, 40, …; wrap pulses on every 50 after the first; sweep_count increments on each wrap.
  - mode = 2 with the same values → 50, 40, 30, 40, 50, 40, …; wrap fires only on returns to 50.
- Abort, simultaneous strobes and reset:
  - abort at step 110 of the single up sweep → busy = 0 next cycle, step_out = 110, no done.
  - go and abort in the same cycle → no sweep starts.
  - reset = 0 mid-sweep → all outputs return to reset values.
- Degenerate cases:
  - delta = 0, start = 5, stop = 9 → 5, then 9.
  - dwell = 0 without the macro → 1 cycle per word.
  - dwell = 0 with DDS_SWEEP_EXT_STEP_EN → a word advances only after an ext_step pulse.
